// File: rtl/f_mult_round.sv
// f_mult_round: two-stage normalize / round / pack back end for the binary32
// multiplier. Stage 1 normalizes the 48-bit significand product and
// denormalizes tiny results; stage 2 rounds, resolves overflow and packs the
// result with its accrued flags {NV,DZ,OF,UF,NX}. Special operands resolved
// upstream ride through both stages unchanged.
module f_mult_round (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sign,
  input  logic signed [9:0]  exp_sum,
  input  logic [47:0]        mant,
  input  logic [2:0]         rounding,
  input  logic               in_special,
  input  logic [31:0]        special_result,
  input  logic [4:0]         special_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        y,
  output logic [4:0]         flags
);

  // Round-increment decision; modes 101..111 fall back to nearest-even.
  function automatic logic round_inc(input logic [2:0] rm, input logic s,
                                     input logic lsb, input logic g,
                                     input logic st);
    logic nx;
    nx = g | st;
    case (rm)
      3'b001:  round_inc = 1'b0;
      3'b010:  round_inc = nx & s;
      3'b011:  round_inc = nx & ~s;
      3'b100:  round_inc = g;
      default: round_inc = g & (st | lsb);
    endcase
  endfunction

  // Overflow saturates to infinity or to the largest finite magnitude,
  // depending on whether the mode rounds away from zero for this sign.
  function automatic logic [31:0] ovf_result(input logic [2:0] rm,
                                             input logic s);
    logic to_inf;
    case (rm)
      3'b001:  to_inf = 1'b0;
      3'b010:  to_inf = s;
      3'b011:  to_inf = ~s;
      default: to_inf = 1'b1;
    endcase
    ovf_result = to_inf ? {s, 8'hFF, 23'h000000} : {s, 8'hFE, 23'h7FFFFF};
  endfunction

  logic adv;

  logic               vld_p1_q;
  logic               sign_p1_q,  sign_p1_d;
  logic [23:0]        sig_p1_q,   sig_p1_d;
  logic               grd_p1_q,   grd_p1_d;
  logic               stk_p1_q,   stk_p1_d;
  logic [7:0]         exp_p1_q,   exp_p1_d;
  logic               tiny_p1_q,  tiny_p1_d;
  logic               ovf_p1_q,   ovf_p1_d;
  logic [2:0]         rm_p1_q;
  logic               spec_p1_q;
  logic [31:0]        sres_p1_q;
  logic [4:0]         sflg_p1_q;

  logic               vld_p2_q;
  logic [31:0]        y_p2_q,     y_p2_d;
  logic [4:0]         flg_p2_q,   flg_p2_d;

  logic signed [10:0] ne;
  logic [10:0]        sh;
  logic [49:0]        ext;
  logic               inexact;
  logic               inc;
  logic [24:0]        sum;
  logic [8:0]         exp9;
  logic [7:0]         exp_o;
  logic               of;

  assign adv       = ~vld_p2_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2_q;
  assign y         = y_p2_q;
  assign flags     = flg_p2_q;

  // Stage 0 -> 1: normalize the product and denormalize tiny results.
  always_comb begin
    sign_p1_d = sign;
    ext       = '0;
    sh        = '0;
    if (mant[47]) begin
      sig_p1_d = mant[47:24];
      grd_p1_d = mant[23];
      stk_p1_d = |mant[22:0];
      ne       = {exp_sum[9], exp_sum} + 11'sd1;
    end else begin
      sig_p1_d = mant[46:23];
      grd_p1_d = mant[22];
      stk_p1_d = |mant[21:0];
      ne       = {exp_sum[9], exp_sum};
    end
    exp_p1_d  = ne[7:0];
    tiny_p1_d = 1'b0;
    ovf_p1_d  = (ne >= 11'sd255);
    if (ne <= 11'sd0) begin
      tiny_p1_d = 1'b1;
      exp_p1_d  = 8'h00;
      sh        = 11'd1 - ne;
      if (sh >= 11'd26) begin
        stk_p1_d = stk_p1_d | grd_p1_d | (|sig_p1_d);
        sig_p1_d = '0;
        grd_p1_d = 1'b0;
      end else begin
        ext      = {sig_p1_d, grd_p1_d, 25'h0} >> sh[4:0];
        sig_p1_d = ext[49:26];
        grd_p1_d = ext[25];
        stk_p1_d = stk_p1_d | (|ext[24:0]);
      end
    end
  end

  // Stage 1 register: valid is reset, the datapath only loads on advance.
  always_ff @(posedge clk) begin
    if (rst) vld_p1_q <= 1'b0;
    else if (adv) vld_p1_q <= in_valid;
    if (adv) begin
      sign_p1_q <= sign_p1_d;
      sig_p1_q  <= sig_p1_d;
      grd_p1_q  <= grd_p1_d;
      stk_p1_q  <= stk_p1_d;
      exp_p1_q  <= exp_p1_d;
      tiny_p1_q <= tiny_p1_d;
      ovf_p1_q  <= ovf_p1_d;
      rm_p1_q   <= rounding;
      spec_p1_q <= in_special;
      sres_p1_q <= special_result;
      sflg_p1_q <= special_flags;
    end
  end

  // Stage 1 -> 2: round, detect carry-into-overflow, pack and raise flags.
  always_comb begin
    inexact = grd_p1_q | stk_p1_q;
    inc     = round_inc(rm_p1_q, sign_p1_q, sig_p1_q[0], grd_p1_q, stk_p1_q);
    sum     = {1'b0, sig_p1_q} + {24'h0, inc};
    exp9    = {1'b0, exp_p1_q} + {8'h00, sum[24]};
    if (tiny_p1_q) begin
      // A subnormal that rounds up into bit 23 becomes the smallest normal.
      exp_o = {7'h00, sum[23]};
      of    = 1'b0;
    end else begin
      exp_o = exp9[7:0];
      of    = ovf_p1_q | (exp9 == 9'd255);
    end
    if (spec_p1_q) begin
      y_p2_d   = sres_p1_q;
      flg_p2_d = sflg_p1_q;
    end else if (of) begin
      y_p2_d   = ovf_result(rm_p1_q, sign_p1_q);
      flg_p2_d = 5'b00101;
    end else begin
      y_p2_d   = {sign_p1_q, exp_o, sum[22:0]};
      flg_p2_d = {2'b00, 1'b0, tiny_p1_q & inexact, inexact};
    end
  end

  // Stage 2 register: result holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      y_p2_q   <= 32'h0;
      flg_p2_q <= 5'h0;
    end else if (adv) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        y_p2_q   <= y_p2_d;
        flg_p2_q <= flg_p2_d;
      end
    end
  end

endmodule

// File: tb/tb_f_mult_round.sv
// Directed bench for f_mult_round: table of hand-computed vectors plus
// backpressure and mid-flight reset sequences.
module tb_f_mult_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [9:0]  exp_sum;
  logic [47:0] mant;
  logic [2:0]  rounding;
  logic        in_special;
  logic [31:0] special_result;
  logic [4:0]  special_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [4:0]  flags;

  int pass_cnt = 0;
  int total_cnt = 0;

  f_mult_round dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .exp_sum(exp_sum), .mant(mant), .rounding(rounding),
    .in_special(in_special), .special_result(special_result),
    .special_flags(special_flags), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [9:0]  es;
    logic [47:0] m;
    logic [2:0]  rm;
    logic        sp;
    logic [31:0] sres;
    logic [4:0]  sflg;
    logic [31:0] ey;
    logic [4:0]  ef;
  } vec_t;

  localparam int NV = 21;
  vec_t tv[NV];

  function automatic vec_t mk(input logic s, input logic [9:0] es,
                              input logic [47:0] m, input logic [2:0] rm,
                              input logic [31:0] ey, input logic [4:0] ef);
    vec_t v;
    v.sgn = s; v.es = es; v.m = m; v.rm = rm;
    v.sp = 1'b0; v.sres = 32'h0; v.sflg = 5'h0;
    v.ey = ey; v.ef = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    sign = v.sgn; exp_sum = v.es; mant = v.m; rounding = v.rm;
    in_special = v.sp; special_result = v.sres; special_flags = v.sflg;
  endtask

  // Apply one vector with the consumer always ready; check 2-cycle latency.
  task automatic run_vec(input int i);
    @(negedge clk);
    drive(tv[i]);
    in_valid = 1'b1;
    chk($sformatf("v%0d_in_ready", i), {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_valid_c1", i), {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    chk($sformatf("v%0d_valid_c2", i), {31'h0, out_valid}, 32'h1);
    chk($sformatf("v%0d_y", i), y, tv[i].ey);
    chk($sformatf("v%0d_flags", i), {27'h0, flags}, {27'h0, tv[i].ef});
  endtask

  int bp[3];
  int idx;
  int got;
  bit saw_block;
  bit take;

  initial begin
    // Normal and rounding-mode cases
    tv[0]  = mk(1'b0, 10'd127, 48'h9000_0000_0000, 3'b000, 32'h40100000, 5'b00000);
    tv[1]  = mk(1'b0, 10'd127, 48'h4000_00C0_0000, 3'b000, 32'h3F800002, 5'b00001);
    tv[2]  = mk(1'b0, 10'd127, 48'h4000_00C0_0000, 3'b001, 32'h3F800001, 5'b00001);
    tv[3]  = mk(1'b0, 10'd127, 48'h4000_00C0_0000, 3'b100, 32'h3F800002, 5'b00001);
    // Overflow
    tv[4]  = mk(1'b0, 10'd254, 48'h8000_0000_0000, 3'b000, 32'h7F800000, 5'b00101);
    tv[5]  = mk(1'b0, 10'd254, 48'h8000_0000_0000, 3'b001, 32'h7F7FFFFF, 5'b00101);
    tv[6]  = mk(1'b1, 10'd254, 48'h8000_0000_0000, 3'b011, 32'hFF7FFFFF, 5'b00101);
    // Underflow
    tv[7]  = mk(1'b0, 10'd0,   48'h4000_0000_0000, 3'b000, 32'h00400000, 5'b00000);
    tv[8]  = mk(1'b0, 10'd0,   48'h4000_0080_0000, 3'b000, 32'h00400000, 5'b00011);
    tv[9]  = mk(1'b0, 10'h3D8, 48'h4000_0000_0000, 3'b000, 32'h00000000, 5'b00011);
    // Special bypass (operand fields would otherwise overflow)
    tv[10] = mk(1'b0, 10'd254, 48'h8000_0000_0000, 3'b000, 32'h7FC00000, 5'b10000);
    tv[10].sp = 1'b1; tv[10].sres = 32'h7FC00000; tv[10].sflg = 5'b10000;
    // Directed rounding, carry and shift boundaries
    tv[11] = mk(1'b1, 10'd127, 48'h4000_00C0_0000, 3'b010, 32'hBF800002, 5'b00001);
    tv[12] = mk(1'b0, 10'd127, 48'h4000_0080_0001, 3'b011, 32'h3F800002, 5'b00001);
    tv[13] = mk(1'b0, 10'd127, 48'h7FFF_FFC0_0000, 3'b000, 32'h40000000, 5'b00001);
    tv[14] = mk(1'b0, 10'd254, 48'h7FFF_FFC0_0000, 3'b000, 32'h7F800000, 5'b00101);
    tv[15] = mk(1'b0, 10'd0,   48'h7FFF_FFC0_0000, 3'b000, 32'h00800000, 5'b00011);
    tv[16] = mk(1'b0, 10'h3FF, 48'h8000_0000_0000, 3'b000, 32'h00400000, 5'b00000);
    tv[17] = mk(1'b0, 10'h3E8, 48'h4000_0000_0000, 3'b011, 32'h00000001, 5'b00011);
    tv[18] = mk(1'b0, 10'h3E9, 48'h4000_0000_0000, 3'b000, 32'h00000000, 5'b00011);
    tv[19] = mk(1'b0, 10'd127, 48'h4000_00C0_0000, 3'b111, 32'h3F800002, 5'b00001);
    tv[20] = mk(1'b1, 10'd254, 48'h8000_0000_0000, 3'b010, 32'hFF800000, 5'b00101);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(tv[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_y", y, 32'h0);
    chk("rst_flags", {27'h0, flags}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Backpressure: three ops pushed while the consumer stalls 4 cycles.
    bp[0] = 0; bp[1] = 4; bp[2] = 7;
    idx = 0; got = 0; saw_block = 1'b0;
    for (int k = 0; k < 30 && got < 3; k++) begin
      @(negedge clk);
      out_ready = (k >= 4);
      if (idx < 3) begin
        drive(tv[bp[idx]]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        chk($sformatf("bp_y_%0d", got), y, tv[bp[got]].ey);
        chk($sformatf("bp_flags_%0d", got), {27'h0, flags},
            {27'h0, tv[bp[got]].ef});
        if (out_ready) got++;
      end
      if (in_valid && !in_ready) saw_block = 1'b1;
      take = in_valid && in_ready;
      @(posedge clk);
      if (take) idx++;
    end
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_delivered", got, 3);
    chk("bp_in_ready_dropped", {31'h0, saw_block}, 32'h1);

    // Reset with two operations in flight.
    @(negedge clk);
    drive(tv[0]); in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(tv[4]);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_y", y, 32'h0);
    chk("mid_rst_flags", {27'h0, flags}, 32'h0);
    rst = 1'b0;
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_valid_%0d", k), {31'h0, out_valid}, 32'h0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
